// File: rtl/uart_rx_checked.sv
// uart_rx_checked: 8N1 UART receiver with 2-FF synchroniser, 3-sample majority vote,
// start-glitch rejection, framing-error and break detection. Optional parity: UART_RX_PARITY_EN.
module uart_rx_checked #(
    parameter int CLKS_PER_BIT = 217
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD   = 1'b0
`endif
) (
    input  logic       i_Clock,
    input  logic       i_Rst_L,
    input  logic       i_RX_Serial,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_RX_Active,
    output logic       o_Frame_Err,
    output logic       o_Break,
    output logic       o_Parity_Err
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] MID_M1_C  = CNT_W'((CLKS_PER_BIT - 1) / 2 - 1);
    localparam logic [CNT_W-1:0] MID_C     = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] MID_P1_C  = CNT_W'((CLKS_PER_BIT - 1) / 2 + 1);
    localparam logic [CNT_W-1:0] LAST_C    = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE_C = CNT_W'(1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd4;
    localparam logic [2:0] S_WAIT_IDLE = 3'd5;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY    = 3'd3;
`endif

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

`ifdef UART_RX_PARITY_EN
    function automatic logic parity8(input logic [7:0] d);
        return ^d;
    endfunction
`endif

    logic             sync1_q, sync2_q;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [1:0]       samp_q, samp_d;
    logic [7:0]       byte_q, byte_d;
    logic             dv_q, dv_d;
    logic             ferr_q, ferr_d;
    logic             brk_q, brk_d;
    logic             active_q, active_d;
    logic             s_s, vote_s, resolve_s;
`ifdef UART_RX_PARITY_EN
    logic             par_q, par_d;
    logic             perr_q, perr_d;
`endif

    assign s_s       = sync2_q;
    assign vote_s    = maj3(samp_q[0], samp_q[1], s_s);
    assign resolve_s = (cnt_q == MID_P1_C);

    // Two-flop synchroniser on the asynchronous serial line, idling high
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= i_RX_Serial;
            sync2_q <= sync1_q;
        end
    end

    // Next-state logic: bit timing, voting, framing decisions
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        dv_d    = 1'b0;
        ferr_d  = 1'b0;
        brk_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        if (cnt_q == MID_M1_C) begin
            samp_d = {samp_q[1], s_s};
        end else if (cnt_q == MID_C) begin
            samp_d = {s_s, samp_q[0]};
        end else begin
            samp_d = samp_q;
        end
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!s_s) begin
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (resolve_s && vote_s) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == LAST_C) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE_C;
                end
            end
            S_DATA: begin
                if (resolve_s) begin
                    shift_d = {vote_s, shift_q[7:1]};
                end else begin
                    shift_d = shift_q;
                end
                if (cnt_q == LAST_C) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE_C;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (resolve_s) begin
                    par_d = vote_s;
                end else begin
                    par_d = par_q;
                end
                if (cnt_q == LAST_C) begin
                    cnt_d   = '0;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE_C;
                end
            end
`endif
            // The rest of a good stop bit is not waited out so back-to-back frames are caught
            S_STOP: begin
                if (resolve_s) begin
                    cnt_d = '0;
                    if (vote_s) begin
                        byte_d  = shift_q;
                        dv_d    = 1'b1;
                        state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
                        perr_d  = (par_q != (parity8(shift_q) ^ PARITY_ODD));
`endif
                    end else begin
                        ferr_d  = 1'b1;
                        brk_d   = (shift_q == 8'h00);
                        state_d = S_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE_C;
                end
            end
            S_WAIT_IDLE: begin
                cnt_d = '0;
                if (s_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        active_d = (state_d == S_START) || (state_d == S_DATA) || (state_d == S_STOP)
`ifdef UART_RX_PARITY_EN
                   || (state_d == S_PARITY)
`endif
                   ;
    end

    // State, datapath and registered outputs
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= 3'd0;
            shift_q  <= 8'h00;
            samp_q   <= 2'b00;
            byte_q   <= 8'h00;
            dv_q     <= 1'b0;
            ferr_q   <= 1'b0;
            brk_q    <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            samp_q   <= samp_d;
            byte_q   <= byte_d;
            dv_q     <= dv_d;
            ferr_q   <= ferr_d;
            brk_q    <= brk_d;
            active_q <= active_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity bit capture and parity-error pulse
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            par_q  <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            par_q  <= par_d;
            perr_q <= perr_d;
        end
    end
    assign o_Parity_Err = perr_q;
`else
    assign o_Parity_Err = 1'b0;
`endif

    assign o_RX_DV     = dv_q;
    assign o_RX_Byte   = byte_q;
    assign o_RX_Active = active_q;
    assign o_Frame_Err = ferr_q;
    assign o_Break     = brk_q;
endmodule

// File: tb/tb_uart_rx_checked.sv
// Bench for uart_rx_checked: directed scenarios plus random frames, checked against an
// event-level frame model (expected DV/frame-error/break events per frame sent).
`timescale 1ns/1ps
module tb_uart_rx_checked;
    localparam int CPB = 217;
    localparam int MID = (CPB - 1) / 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       dv, active, ferr, brk, perr;
    logic [7:0] rbyte;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int dv_cyc = 0;
    logic [7:0] last_good = 8'h00;

    // event encoding: {kind[1:0], break, parity_err, byte}; kind 1 = DV, 2 = frame error, 3 = stray
    logic [11:0] obs_q[$];
    logic [11:0] exp_q[$];

    uart_rx_checked #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock     (clk),
        .i_Rst_L     (rst_n),
        .i_RX_Serial (rx),
        .o_RX_DV     (dv),
        .o_RX_Byte   (rbyte),
        .o_RX_Active (active),
        .o_Frame_Err (ferr),
        .o_Break     (brk),
        .o_Parity_Err(perr)
    );

    always #20 clk = ~clk;

    // Output monitor: turns pulses into events, sampled on the falling edge
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (dv) begin
            obs_q.push_back({2'd1, 1'b0, perr, rbyte});
            dv_cyc <= cyc;
        end
        if (ferr) obs_q.push_back({2'd2, brk, 1'b0, 8'h00});
        else if (brk) obs_q.push_back({2'd3, 1'b1, 1'b0, 8'h00});
        if (perr && !dv) obs_q.push_back({2'd3, 1'b0, 1'b1, 8'h00});
        if (dv && ferr) obs_q.push_back({2'd3, 1'b1, 1'b1, 8'hFF});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    // Reference: what one frame should produce at the byte-level interface
    function automatic logic [11:0] model(input logic [7:0] b, input logic stop_ok, input logic par_bad);
        logic pe;
`ifdef UART_RX_PARITY_EN
        pe = par_bad;
`else
        pe = 1'b0;
`endif
        if (stop_ok) return {2'd1, 1'b0, pe, b};
        return {2'd2, (b == 8'h00), 1'b0, 8'h00};
    endfunction

    task automatic send(input logic [7:0] b, input logic stop_ok, input logic par_bad, input int glitch_bit);
        start_cyc = cyc;
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) begin
            if (i == glitch_bit) begin
                hold(b[i], MID + 1);
                hold(~b[i], 1);
                hold(b[i], CPB - MID - 2);
            end else begin
                hold(b[i], CPB);
            end
        end
`ifdef UART_RX_PARITY_EN
        hold((^b) ^ par_bad, CPB);
`endif
        hold(stop_ok, CPB);
        exp_q.push_back(model(b, stop_ok, par_bad));
        if (stop_ok) last_good = b;
    endtask

    task automatic check_events(input string tag);
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            chk({tag, "_event"}, {20'h0, obs_q.pop_front()}, {20'h0, exp_q.pop_front()});
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] rb;
        logic       rs, rp;
        int         gap;

        repeat (3) @(negedge clk);
        chk("rst_dv", dv, 1'b0);
        chk("rst_byte", rbyte, 8'h00);
        chk("rst_active", active, 1'b0);
        chk("rst_ferr", ferr, 1'b0);
        chk("rst_break", brk, 1'b0);
        chk("rst_perr", perr, 1'b0);
        rst_n = 1'b1;
        hold(1'b1, 10);

        // clean frame and latency from the start edge
        send(8'h3F, 1'b1, 1'b0, -1);
        hold(1'b1, 20);
        check_events("clean");
        chk("clean_byte", rbyte, 8'h3F);
        chk("latency_window", ((dv_cyc - start_cyc) >= 9 * CPB + MID + 2) &&
                              ((dv_cyc - start_cyc) <= 9 * CPB + MID + 6), 1'b1);

        // start glitch shorter than half a bit
        hold(1'b0, 50);
        hold(1'b1, 2 * CPB);
        check_events("glitch");
        chk("glitch_active", active, 1'b0);
        send(8'h12, 1'b1, 1'b0, -1);
        hold(1'b1, 20);
        check_events("after_glitch");

        // framing error with non-zero data
        send(8'h55, 1'b0, 1'b0, -1);
        hold(1'b1, CPB);
        check_events("framing");
        chk("framing_byte_hold", rbyte, 8'h12);

        // break: 12 bit periods low
        hold(1'b0, 12 * CPB);
        exp_q.push_back(model(8'h00, 1'b0, 1'b0));
        hold(1'b1, CPB);
        check_events("break");
        chk("break_byte_hold", rbyte, 8'h12);
        send(8'hC3, 1'b1, 1'b0, -1);
        hold(1'b1, 20);
        check_events("after_break");

        // back-to-back, then with a one-clock glitch on the middle sample of bit 3
        send(8'hA5, 1'b1, 1'b0, -1);
        send(8'h5A, 1'b1, 1'b0, -1);
        hold(1'b1, 20);
        check_events("b2b");
        send(8'hA5, 1'b1, 1'b0, 3);
        send(8'h5A, 1'b1, 1'b0, 3);
        hold(1'b1, 20);
        check_events("b2b_vote");

        // reset during data bit 4
        hold(1'b0, CPB);
        for (int i = 0; i < 4; i++) hold(1'b1, CPB);
        hold(1'b0, MID);
        chk("midframe_active", active, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_dv", dv, 1'b0);
        chk("mid_rst_byte", rbyte, 8'h00);
        chk("mid_rst_active", active, 1'b0);
        chk("mid_rst_ferr", ferr, 1'b0);
        chk("mid_rst_break", brk, 1'b0);
        @(negedge clk);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        hold(1'b1, 2 * CPB);
        check_events("aborted");
        send(8'h81, 1'b1, 1'b0, -1);
        hold(1'b1, 20);
        check_events("after_reset");

`ifdef UART_RX_PARITY_EN
        send(8'h07, 1'b1, 1'b1, -1);
        hold(1'b1, 20);
        check_events("parity_bad");
        chk("parity_byte", rbyte, 8'h07);
`endif

        // random frames with random idle gaps
        for (int n = 0; n < 6; n++) begin
            rb  = 8'($urandom_range(0, 255));
            rs  = ($urandom_range(0, 3) != 0);
            rp  = 1'($urandom_range(0, 1));
            gap = rs ? $urandom_range(0, 2) : $urandom_range(1, 2);
            send(rb, rs, rp, -1);
            hold(1'b1, gap * CPB);
        end
        hold(1'b1, 20);
        check_events("random");
        chk("random_last_byte", rbyte, last_good);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
